// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : Oversampling UART receive controller. A programmable tick
//               generator drives 16x (OVERSAMPLE) bit timing. The start bit
//               is validated at its midpoint and 8 data bits are sampled
//               LSB-first at bit centres. The stop bit is then checked.
//               Completed bytes go to a one-entry holding register with a
//               valid/ready handshake. Framing-error and overrun are
//               reported as single-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic             rx_clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             rx,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int                SAMP_W     = $clog2(OVERSAMPLE);
    localparam logic [SAMP_W-1:0] C_SAMP_MID = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] C_SAMP_END = SAMP_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_rx_meta;
    logic              r_rx_s;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [DIV_W-1:0]  w_div_cnt_nxt;
    logic [SAMP_W-1:0] r_samp_cnt;
    logic [SAMP_W-1:0] w_samp_cnt_nxt;
    logic [3:0]        r_bit_cnt;
    logic [3:0]        w_bit_cnt_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic              w_tick;
    logic              w_pop;
    logic              w_load;
    logic              w_ferr;
    logic              w_ovr;

    assign w_tick = (r_div_cnt == baud_div);
    assign w_pop  = rx_valid && rx_ready;
    assign busy   = (r_state != ST_IDLE);

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // State register
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter and event decode
    always_comb begin
        w_state_nxt    = r_state;
        w_div_cnt_nxt  = r_div_cnt;
        w_samp_cnt_nxt = r_samp_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_load         = 1'b0;
        w_ferr         = 1'b0;
        w_ovr          = 1'b0;

        // Free-running tick/oversample counting while a frame is active
        if (r_state != ST_IDLE) begin
            w_div_cnt_nxt = w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_tick) begin
                w_samp_cnt_nxt = r_samp_cnt + 1'b1;
            end
        end

        case (r_state)
            ST_IDLE: begin
                w_div_cnt_nxt  = '0;
                w_samp_cnt_nxt = '0;
                w_bit_cnt_nxt  = '0;
                if (!r_rx_s) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                // Mid start bit: a high line here was only a glitch
                if (w_tick && r_samp_cnt == C_SAMP_MID) begin
                    w_samp_cnt_nxt = '0;
                    w_bit_cnt_nxt  = '0;
                    w_state_nxt    = r_rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick && r_samp_cnt == C_SAMP_END) begin
                    w_shift_nxt   = {r_rx_s, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
                        w_state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick && r_samp_cnt == C_SAMP_END) begin
                    if (r_rx_s) begin
                        // A same-cycle pop frees the holding register
                        if (!rx_valid || w_pop) begin
                            w_load = 1'b1;
                        end else begin
                            w_ovr = 1'b1;
                        end
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Stay here until the line is released so a held-low
                // line cannot look like a fresh start bit
                if (r_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Disable aborts the frame silently; holding register is untouched
        if (!enable) begin
            w_state_nxt    = ST_IDLE;
            w_div_cnt_nxt  = '0;
            w_samp_cnt_nxt = '0;
            w_bit_cnt_nxt  = '0;
            w_load         = 1'b0;
            w_ferr         = 1'b0;
            w_ovr          = 1'b0;
        end
    end

    // Counters and receive shift register
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt  <= '0;
            r_samp_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            r_div_cnt  <= w_div_cnt_nxt;
            r_samp_cnt <= w_samp_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
        end
    end

    // Holding register, handshake and single-cycle status pulses
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_load) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end else if (w_pop) begin
                rx_valid <= 1'b0;
            end
            frame_err <= w_ferr;
            overrun   <= w_ovr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Directed self-checking bench for uart_rx_ctrl (OVERSAMPLE=16)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    logic        rx_clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] baud_div;
    logic        rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int both_cnt = 0;

    uart_rx_ctrl #(
        .OVERSAMPLE (16),
        .DIV_W      (16)
    ) u_dut (
        .rx_clk    (rx_clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .baud_div  (baud_div),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 rx_clk = ~rx_clk;

    // Count flag-high cycles; a single-cycle pulse adds exactly one
    always @(negedge rx_clk) begin
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (frame_err && overrun) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start bit, 8 data bits LSB-first, stop level held for stop_bits bit times
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input int bitc, input int stop_bits);
        @(posedge rx_clk); #1;
        rx = 1'b0;
        repeat (bitc) @(posedge rx_clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (bitc) @(posedge rx_clk);
            #1;
        end
        rx = stop;
        repeat (bitc * stop_bits) @(posedge rx_clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        @(posedge rx_clk); #1;
        rx_ready = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        baud_div = 16'd0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        wait_cycles(3);

        // Reset values
        check_eq("rst_data",  rx_data,   8'h00);
        check_eq("rst_valid", rx_valid,  1'b0);
        check_eq("rst_ferr",  frame_err, 1'b0);
        check_eq("rst_ovr",   overrun,   1'b0);
        check_eq("rst_busy",  busy,      1'b0);

        reset_n = 1'b1;
        wait_cycles(1);
        enable = 1'b1;

        // Basic 0xA5 frame; start at P0, stop-centre tick at P155
        fork
            send_frame(8'hA5, 1'b1, 16, 1);
            begin
                wait_cycles(1);
                wait_cycles(154);
                check_eq("lat_pre", rx_valid, 1'b0);
                wait_cycles(1);
                check_eq("lat_post", rx_valid, 1'b1);
            end
        join
        wait_cycles(4);
        check_eq("a5_data",  rx_data,  8'hA5);
        check_eq("a5_valid", rx_valid, 1'b1);
        check_eq("a5_busy",  busy,     1'b0);
        check_eq("a5_ferr",  ferr_cnt, 0);
        wait_cycles(20);
        check_eq("a5_hold_valid", rx_valid, 1'b1);
        check_eq("a5_hold_data",  rx_data,  8'hA5);
        pop_one();
        check_eq("a5_pop", rx_valid, 1'b0);

        // Glitch: 4 low cycles at baud_div=3, midpoint check ~32 cycles in
        baud_div = 16'd3;
        wait_cycles(1);
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(16);
        check_eq("glitch_busy_mid", busy, 1'b1);
        wait_cycles(20);
        check_eq("glitch_busy_end", busy,     1'b0);
        check_eq("glitch_valid",    rx_valid, 1'b0);
        check_eq("glitch_flags",    ferr_cnt + ovr_cnt, 0);

        // Framing error: 0x3C with stop low for 3 bit times
        baud_div = 16'd0;
        send_frame(8'h3C, 1'b0, 16, 3);
        check_eq("ferr_count", ferr_cnt, 1);
        check_eq("ferr_valid", rx_valid, 1'b0);
        check_eq("ferr_busy_low", busy, 1'b1);
        rx = 1'b1;
        wait_cycles(6);
        check_eq("ferr_busy_rel", busy, 1'b0);
        check_eq("ferr_ovr", ovr_cnt, 0);

        // Overrun: 0x11 then 0x22 with no consumer
        send_frame(8'h11, 1'b1, 16, 1);
        send_frame(8'h22, 1'b1, 16, 1);
        wait_cycles(4);
        check_eq("ovr_count", ovr_cnt,  1);
        check_eq("ovr_data",  rx_data,  8'h11);
        check_eq("ovr_valid", rx_valid, 1'b1);
        check_eq("ovr_ferr",  ferr_cnt, 1);
        pop_one();
        check_eq("ovr_pop_valid", rx_valid, 1'b0);
        check_eq("ovr_pop_data",  rx_data,  8'h11);

        // Simultaneous pop and load on the 0x22 stop tick
        send_frame(8'h11, 1'b1, 16, 1);
        wait_cycles(2);
        check_eq("sim_pre_data", rx_data, 8'h11);
        fork
            send_frame(8'h22, 1'b1, 16, 1);
            begin
                wait_cycles(1);
                wait_cycles(154);
                rx_ready = 1'b1;
                wait_cycles(1);
                rx_ready = 1'b0;
                check_eq("sim_valid_now", rx_valid, 1'b1);
            end
        join
        wait_cycles(4);
        check_eq("sim_data",  rx_data,  8'h22);
        check_eq("sim_valid", rx_valid, 1'b1);
        check_eq("sim_ovr",   ovr_cnt,  1);
        pop_one();

        // Abort mid-frame by dropping enable
        fork
            send_frame(8'h5A, 1'b1, 16, 1);
            begin
                wait_cycles(1);
                wait_cycles(60);
                check_eq("abort_busy_pre", busy, 1'b1);
                enable = 1'b0;
                wait_cycles(1);
                check_eq("abort_idle", busy, 1'b0);
            end
        join
        enable = 1'b1;
        wait_cycles(4);
        check_eq("abort_valid", rx_valid, 1'b0);
        send_frame(8'h5A, 1'b1, 16, 1);
        wait_cycles(4);
        check_eq("5a_data",  rx_data,  8'h5A);
        check_eq("5a_valid", rx_valid, 1'b1);
        check_eq("5a_flags", ferr_cnt + ovr_cnt, 2);

        // Asynchronous reset mid-frame
        fork
            send_frame(8'hA5, 1'b1, 16, 1);
            begin
                wait_cycles(1);
                wait_cycles(50);
                reset_n = 1'b0;
                #1;
                check_eq("arst_valid", rx_valid, 1'b0);
                check_eq("arst_data",  rx_data,  8'h00);
                check_eq("arst_busy",  busy,     1'b0);
            end
        join
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(4);
        check_eq("both_flags", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
